keypad_entry: RTL and testbench

- Parametrised keypad front end: scans a ROWS x COLS matrix keypad, debounces each press and release, and emits one key event per physical press.
- Maintains a DIGITS-deep entry buffer of BCD digits with clear and backspace keys.
- Drives the FTSD decode/scan path directly with a multi-digit number instead of a single raw key.
- Replaces free-running scan plus level "pressed" with debounced, edge-qualified events.

---
 rtl/keypad_entry_if.sv | 25 ++
 rtl/keypad_entry.sv | 149 ++++++++++++++
 tb/tb_keypad_entry.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// Keypad matrix lines and decoded entry outputs of keypad_entry.
// slave is the keypad_entry side; master is whoever owns the keypad and consumes the entry.
interface keypad_entry_if #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DIGITS = 4
);
    logic [COLS-1:0]     col_in;
    logic [ROWS-1:0]     row_scn;
    logic [3:0]          key_code;
    logic                key_valid;
    logic                pressed;
    logic [4*DIGITS-1:0] digits;
    logic [3:0]          digit_cnt;

    modport master (
        output col_in,
        input  row_scn, key_code, key_valid, pressed, digits, digit_cnt
    );

    modport slave (
        input  col_in,
        output row_scn, key_code, key_valid, pressed, digits, digit_cnt
    );
endinterface

// File: rtl/keypad_entry.sv
// Matrix keypad scanner with per-key debounce, one event per press,
// and a BCD entry buffer supporting clear and backspace keys.
module keypad_entry #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 10000,
    parameter int DEBOUNCE = 4,
    parameter int DIGITS   = 4,
    parameter int CLR_KEY  = 14,
    parameter int BS_KEY   = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    keypad_entry_if.slave  kp
);
    localparam int TICK_W = $clog2(SCAN_DIV);
    localparam int DBC_W  = $clog2(DEBOUNCE + 1);
    localparam int BUF_W  = 4 * DIGITS;

    localparam logic [1:0] ST_SCAN = 2'd0;
    localparam logic [1:0] ST_DEB  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [3:0] CLR_CODE = 4'(CLR_KEY);
    localparam logic [3:0] BS_CODE  = 4'(BS_KEY);
    localparam logic [3:0] MAX_CNT  = 4'(DIGITS);

    logic [COLS-1:0]   col_p0, col_p1;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [1:0]        state;
    logic [1:0]        row_idx, col_idx, row_next, low_col;
    logic [DBC_W-1:0]  dbc;
    logic              dbc_done, any_low, all_high, sel_low;
    logic              pressed_r, key_valid_r;
    logic [3:0]        key_code_r, new_code, digit_cnt_r, cnt_nxt;
    logic [BUF_W-1:0]  digits_r, digits_nxt;

    // Lowest-index closed column wins when several are low on one row.
    function automatic logic [1:0] lowest_low(input logic [COLS-1:0] cols);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = COLS - 1; i >= 0; i--) begin
            if (!cols[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    assign tick     = (tick_cnt == TICK_W'(SCAN_DIV - 1));
    assign any_low  = ~&col_p1;
    assign all_high = &col_p1;
    assign sel_low  = ~col_p1[col_idx];
    assign low_col  = lowest_low(col_p1);
    assign dbc_done = (dbc == DBC_W'(DEBOUNCE - 1));
    assign row_next = (row_idx == 2'(ROWS - 1)) ? 2'd0 : row_idx + 2'd1;
    assign new_code = 4'(int'(row_idx) * COLS + int'(col_idx));

    // Buffer contents that take effect on the edge that reports new_code.
    always_comb begin
        digits_nxt = digits_r;
        cnt_nxt    = digit_cnt_r;
        if (new_code == CLR_CODE) begin
            digits_nxt = '0;
            cnt_nxt    = '0;
        end else if (new_code == BS_CODE) begin
            digits_nxt = digits_r >> 4;
            if (digit_cnt_r != 4'd0) cnt_nxt = digit_cnt_r - 4'd1;
        end else if (new_code <= 4'd9) begin
            digits_nxt = (digits_r << 4) | BUF_W'(new_code);
            if (digit_cnt_r < MAX_CNT) cnt_nxt = digit_cnt_r + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_p0      <= '1;
            col_p1      <= '1;
            tick_cnt    <= '0;
            state       <= ST_SCAN;
            row_idx     <= 2'd0;
            col_idx     <= 2'd0;
            dbc         <= '0;
            pressed_r   <= 1'b0;
            key_valid_r <= 1'b0;
            key_code_r  <= 4'd0;
            digits_r    <= '0;
            digit_cnt_r <= 4'd0;
        end else begin
            col_p0      <= kp.col_in;
            col_p1      <= col_p0;
            tick_cnt    <= tick ? '0 : tick_cnt + TICK_W'(1);
            key_valid_r <= 1'b0;
            if (tick) begin
                case (state)
                    ST_SCAN: begin
                        if (any_low) begin
                            col_idx <= low_col;
                            dbc     <= '0;
                            state   <= ST_DEB;
                        end else begin
                            row_idx <= row_next;
                        end
                    end
                    ST_DEB: begin
                        if (sel_low) begin
                            if (dbc_done) begin
                                state       <= ST_HOLD;
                                dbc         <= '0;
                                pressed_r   <= 1'b1;
                                key_valid_r <= 1'b1;
                                key_code_r  <= new_code;
                                digits_r    <= digits_nxt;
                                digit_cnt_r <= cnt_nxt;
                            end else begin
                                dbc <= dbc + DBC_W'(1);
                            end
                        end else begin
                            state   <= ST_SCAN;
                            row_idx <= row_next;
                        end
                    end
                    // Release needs DEBOUNCE consecutive all-high ticks; any closure restarts it.
                    ST_HOLD: begin
                        if (all_high) begin
                            if (dbc_done) begin
                                state     <= ST_SCAN;
                                dbc       <= '0;
                                pressed_r <= 1'b0;
                                row_idx   <= row_next;
                            end else begin
                                dbc <= dbc + DBC_W'(1);
                            end
                        end else begin
                            dbc <= '0;
                        end
                    end
                    default: state <= ST_SCAN;
                endcase
            end
        end
    end

    assign kp.row_scn   = ~(ROWS'(1) << row_idx);
    assign kp.key_code  = key_code_r;
    assign kp.key_valid = key_valid_r;
    assign kp.pressed   = pressed_r;
    assign kp.digits    = digits_r;
    assign kp.digit_cnt = digit_cnt_r;
endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a behavioural key matrix drives col_in
// from row_scn; events and buffer state are checked against hand-computed values.
module tb_keypad_entry;
    localparam int ROWS = 4, COLS = 4, SCAN_DIV = 4, DEBOUNCE = 4, DIGITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_entry_if #(.ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS)) kp();

    keypad_entry #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
        .DIGITS(DIGITS), .CLR_KEY(14), .BS_KEY(15)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .kp(kp)
    );

    logic key_down [16];

    // Closed keys on the driven (low) row pull their column low.
    always_comb begin
        kp.col_in = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!kp.row_scn[r] && key_down[r*COLS+c]) kp.col_in[c] = 1'b0;
    end

    int ev_cnt = 0;
    always @(negedge clk) if (kp.key_valid) ev_cnt++;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_row(input logic [3:0] want);
        int n;
        n = 0;
        while (kp.row_scn !== want && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("row_wait_timeout", 32'(n < 100), 32'd1);
    endtask

    task automatic wait_pressed(input logic lvl, output int n);
        n = 0;
        while (kp.pressed !== lvl && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("pressed_wait_timeout", 32'(n < 300), 32'd1);
    endtask

    task automatic press_release(input int code);
        int n;
        key_down[code] = 1'b1;
        n = 0;
        while (kp.key_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("event_timeout", 32'(n < 300), 32'd1);
        repeat (8) @(negedge clk);
        key_down[code] = 1'b0;
        wait_pressed(1'b0, n);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_row_scn"}, 32'(kp.row_scn), 32'h0000_000E);
        check({tag, "_key_code"}, 32'(kp.key_code), 32'd0);
        check({tag, "_key_valid"}, 32'(kp.key_valid), 32'd0);
        check({tag, "_pressed"}, 32'(kp.pressed), 32'd0);
        check({tag, "_digits"}, 32'(kp.digits), 32'd0);
        check({tag, "_digit_cnt"}, 32'(kp.digit_cnt), 32'd0);
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [15:0] exp_digits;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs [12];
    logic [3:0] row_seq [4];

    initial begin
        int n, ev0;
        for (int i = 0; i < 16; i++) key_down[i] = 1'b0;
        row_seq[0] = 4'b1110; row_seq[1] = 4'b1101;
        row_seq[2] = 4'b1011; row_seq[3] = 4'b0111;

        vecs[0]  = '{4'd1,  16'h0001, 4'd1};
        vecs[1]  = '{4'd2,  16'h0012, 4'd2};
        vecs[2]  = '{4'd3,  16'h0123, 4'd3};
        vecs[3]  = '{4'd4,  16'h1234, 4'd4};
        vecs[4]  = '{4'd5,  16'h2345, 4'd4};
        vecs[5]  = '{4'd15, 16'h0234, 4'd3};
        vecs[6]  = '{4'd14, 16'h0000, 4'd0};
        vecs[7]  = '{4'd15, 16'h0000, 4'd0};
        vecs[8]  = '{4'd9,  16'h0009, 4'd1};
        vecs[9]  = '{4'd12, 16'h0009, 4'd1};
        vecs[10] = '{4'd10, 16'h0009, 4'd1};
        vecs[11] = '{4'd0,  16'h0090, 4'd2};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Idle scan: rows rotate once per tick, no events.
        wait_row(4'b1101);
        for (int i = 0; i < 20; i++) begin
            repeat (SCAN_DIV) @(negedge clk);
            check("idle_row_scn", 32'(kp.row_scn), 32'(row_seq[(i + 2) % 4]));
        end
        check("idle_events", 32'(ev_cnt), 32'd0);
        check("idle_digits", 32'(kp.digits), 32'd0);

        // Clean press of row1/col2: exact latency, hold, and release timing.
        wait_row(4'b1110);
        key_down[6] = 1'b1;
        ev0 = ev_cnt;
        wait_row(4'b1101);
        n = 0;
        while (kp.key_valid !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("press_latency", 32'(n), 32'd20);
        check("press_code", 32'(kp.key_code), 32'd6);
        check("press_pressed", 32'(kp.pressed), 32'd1);
        check("press_digits", 32'(kp.digits), 32'h0006);
        check("press_cnt", 32'(kp.digit_cnt), 32'd1);
        repeat (40) @(negedge clk);
        check("hold_pressed", 32'(kp.pressed), 32'd1);
        check("hold_no_repeat", 32'(ev_cnt - ev0), 32'd1);
        key_down[6] = 1'b0;
        wait_pressed(1'b0, n);
        check("release_latency", 32'(n), 32'd16);

        // Bounce: low two ticks, high one, then steady -> one event only.
        wait_row(4'b1110);
        key_down[6] = 1'b1;
        ev0 = ev_cnt;
        wait_row(4'b1101);
        repeat (8) @(negedge clk);
        key_down[6] = 1'b0;
        repeat (4) @(negedge clk);
        key_down[6] = 1'b1;
        repeat (12) @(negedge clk);
        check("bounce_rejected", 32'(ev_cnt - ev0), 32'd0);
        check("bounce_not_pressed", 32'(kp.pressed), 32'd0);
        wait_pressed(1'b1, n);
        repeat (60) @(negedge clk);
        check("bounce_single_event", 32'(ev_cnt - ev0), 32'd1);
        check("bounce_code", 32'(kp.key_code), 32'd6);
        key_down[6] = 1'b0;
        wait_pressed(1'b0, n);
        check("bounce_digits", 32'(kp.digits), 32'h0066);
        check("bounce_cnt", 32'(kp.digit_cnt), 32'd2);

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Entry buffer sequence.
        for (int i = 0; i < 12; i++) begin
            ev0 = ev_cnt;
            press_release(int'(vecs[i].code));
            check($sformatf("vec%0d_events", i), 32'(ev_cnt - ev0), 32'd1);
            check($sformatf("vec%0d_code", i), 32'(kp.key_code), 32'(vecs[i].code));
            check($sformatf("vec%0d_digits", i), 32'(kp.digits), 32'(vecs[i].exp_digits));
            check($sformatf("vec%0d_cnt", i), 32'(kp.digit_cnt), 32'(vecs[i].exp_cnt));
        end

        // Two columns on row0, then a second key during HOLD.
        ev0 = ev_cnt;
        key_down[1] = 1'b1;
        key_down[3] = 1'b1;
        wait_pressed(1'b1, n);
        check("multi_col_code", 32'(kp.key_code), 32'd1);
        key_down[5] = 1'b1;
        repeat (80) @(negedge clk);
        check("rollover_ignored", 32'(ev_cnt - ev0), 32'd1);
        key_down[1] = 1'b0;
        key_down[3] = 1'b0;
        key_down[5] = 1'b0;
        wait_pressed(1'b0, n);
        repeat (40) @(negedge clk);
        check("rollover_events", 32'(ev_cnt - ev0), 32'd1);
        check("multi_col_digits", 32'(kp.digits), 32'h0901);
        check("multi_col_cnt", 32'(kp.digit_cnt), 32'd3);

        // Reset mid-debounce aborts the press.
        wait_row(4'b1110);
        key_down[5] = 1'b1;
        wait_row(4'b1101);
        repeat (10) @(negedge clk);
        check("middeb_not_pressed", 32'(kp.pressed), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_values("middeb");
        key_down[5] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ev0 = ev_cnt;
        repeat (100) @(negedge clk);
        check("middeb_no_stale_event", 32'(ev_cnt - ev0), 32'd0);
        check("middeb_digits", 32'(kp.digits), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
